// File: rtl/t12t24.sv
// 12-hour to 24-hour BCD hour register: loads a 12-hour BCD value with an
// AM/PM flag, validates and converts it, and advances the hour on CarryIn.
// Latency: Load at edge N -> Hour24/Done at edge N+2; Err at edge N+1.
// Backpressure: Load is ignored while Busy. One CarryIn that arrives while
// Busy is held as pending; any further carries while pending are dropped.
// Ports:
//   CLK, nCR (async active-low reset)
//   Load, Hour12[7:0], PM   - set request, packed BCD 12-hour value
//   CarryIn                 - hour-advance pulse from the minute stage
//   Hour24[7:0]             - registered packed BCD hour, 00..23
//   Busy, Done, Err, DayCarry - registered status pulses and levels
module t12t24 (
  input  logic       CLK,
  input  logic       nCR,
  input  logic       Load,
  input  logic [7:0] Hour12,
  input  logic       PM,
  input  logic       CarryIn,
  output logic [7:0] Hour24,
  output logic       Busy,
  output logic       Done,
  output logic       Err,
  output logic       DayCarry
);

  typedef enum logic [1:0] {IDLE, CHECK, COMMIT} state_t;

  state_t     state_q, state_d;
  logic [7:0] hour_q, hour_d;
  logic [7:0] cap_hr_q, cap_hr_d;
  logic       cap_pm_q, cap_pm_d;
  logic       pend_q, pend_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       day_q, day_d;

  logic [3:0] tens, units;
  logic       valid;
  logic [7:0] conv;
  logic       pend_eff;

  // BCD increment with 23 -> 00 wrap.
  function automatic logic [7:0] bcd_inc(input logic [7:0] h);
    logic [7:0] r;
    if (h == 8'h23)
      r = 8'h00;
    else if (h[3:0] == 4'd9)
      r = {h[7:4] + 4'd1, 4'd0};
    else
      r = {h[7:4], h[3:0] + 4'd1};
    return r;
  endfunction

  assign tens  = cap_hr_q[7:4];
  assign units = cap_hr_q[3:0];
  // tens <= 1 and units <= 9 already excludes non-BCD codes; the range
  // compare then removes 00 and 13..19.
  assign valid = (units <= 4'd9) && (tens <= 4'd1) &&
                 (cap_hr_q != 8'h00) && (cap_hr_q <= 8'h12);

  // PM 01..11 adds 12: tens+1, units+2, with a decimal carry when units+2
  // would exceed 9 (e.g. 09 -> 21).
  always_comb begin
    conv = cap_hr_q;
    if (cap_hr_q == 8'h12)
      conv = cap_pm_q ? 8'h12 : 8'h00;
    else if (!cap_pm_q)
      conv = cap_hr_q;
    else if (units >= 4'd8)
      conv = {tens + 4'd2, units - 4'd8};
    else
      conv = {tens + 4'd1, units + 4'd2};
  end

  // A carry arriving in the same cycle as the decision is treated as if it
  // had already been pending, so it is never lost while Busy.
  assign pend_eff = pend_q | CarryIn;

  always_comb begin
    state_d  = state_q;
    hour_d   = hour_q;
    cap_hr_d = cap_hr_q;
    cap_pm_d = cap_pm_q;
    pend_d   = pend_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    day_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (CarryIn) begin
          hour_d = bcd_inc(hour_q);
          day_d  = (hour_q == 8'h23);
        end
        if (Load) begin
          cap_hr_d = Hour12;
          cap_pm_d = PM;
          state_d  = CHECK;
        end
      end
      CHECK: begin
        if (valid) begin
          state_d = COMMIT;
          pend_d  = pend_eff;
        end else begin
          state_d = IDLE;
          err_d   = 1'b1;
          pend_d  = 1'b0;
          if (pend_eff) begin
            hour_d = bcd_inc(hour_q);
            day_d  = (hour_q == 8'h23);
          end
        end
      end
      COMMIT: begin
        state_d = IDLE;
        done_d  = 1'b1;
        pend_d  = 1'b0;
        if (pend_eff) begin
          hour_d = bcd_inc(conv);
          day_d  = (conv == 8'h23);
        end else begin
          hour_d = conv;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge nCR) begin
    if (!nCR) begin
      state_q  <= IDLE;
      hour_q   <= 8'h00;
      cap_hr_q <= 8'h00;
      cap_pm_q <= 1'b0;
      pend_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      day_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      hour_q   <= hour_d;
      cap_hr_q <= cap_hr_d;
      cap_pm_q <= cap_pm_d;
      pend_q   <= pend_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      day_q    <= day_d;
    end
  end

  assign Hour24   = hour_q;
  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Err      = err_q;
  assign DayCarry = day_q;

endmodule

// File: tb/tb_t12t24.sv
// Testbench for t12t24: table of 12-hour sets with expected 24-hour results,
// plus directed sequences for carry, wrap, pending, reset and held Load.
module tb_t12t24;

  logic       CLK = 1'b0;
  logic       nCR = 1'b0;
  logic       Load = 1'b0;
  logic [7:0] Hour12 = 8'h00;
  logic       PM = 1'b0;
  logic       CarryIn = 1'b0;
  logic [7:0] Hour24;
  logic       Busy, Done, Err, DayCarry;

  int checks = 0;
  int failures = 0;
  logic [7:0] cur;

  typedef struct {
    logic [7:0] hr;
    logic       pm;
    logic [7:0] exp;
    logic       ok;
  } vec_t;

  vec_t vec [28];

  t12t24 dut (
    .CLK(CLK), .nCR(nCR), .Load(Load), .Hour12(Hour12), .PM(PM),
    .CarryIn(CarryIn), .Hour24(Hour24), .Busy(Busy), .Done(Done),
    .Err(Err), .DayCarry(DayCarry)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Drives one set and checks the full response timeline.
  task automatic do_set(input string tag, input logic [7:0] hr, input logic pm,
                        input logic [7:0] exp, input logic ok);
    @(negedge CLK);
    Load = 1'b1; Hour12 = hr; PM = pm;
    @(negedge CLK);
    Load = 1'b0;
    chk({tag, "_busyN"}, Busy, 8'd1);
    chk({tag, "_doneN"}, Done, 8'd0);
    @(negedge CLK);
    if (ok) begin
      chk({tag, "_busyN1"}, Busy, 8'd1);
      chk({tag, "_errN1"}, Err, 8'd0);
      @(negedge CLK);
      chk({tag, "_hour"}, Hour24, exp);
      chk({tag, "_done"}, Done, 8'd1);
      chk({tag, "_busyN2"}, Busy, 8'd0);
      cur = exp;
    end else begin
      chk({tag, "_err"}, Err, 8'd1);
      chk({tag, "_busyN1"}, Busy, 8'd0);
      chk({tag, "_hold"}, Hour24, cur);
    end
    @(negedge CLK);
    chk({tag, "_doneoff"}, Done, 8'd0);
    chk({tag, "_erroff"}, Err, 8'd0);
  endtask

  task automatic carry1(input string tag, input logic [7:0] exp_h, input logic exp_d);
    @(negedge CLK);
    CarryIn = 1'b1;
    @(negedge CLK);
    CarryIn = 1'b0;
    chk({tag, "_hour"}, Hour24, exp_h);
    chk({tag, "_day"}, DayCarry, {7'd0, exp_d});
  endtask

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    vec[0]  = '{8'h01, 1'b0, 8'h01, 1'b1};
    vec[1]  = '{8'h02, 1'b0, 8'h02, 1'b1};
    vec[2]  = '{8'h03, 1'b0, 8'h03, 1'b1};
    vec[3]  = '{8'h04, 1'b0, 8'h04, 1'b1};
    vec[4]  = '{8'h05, 1'b0, 8'h05, 1'b1};
    vec[5]  = '{8'h06, 1'b0, 8'h06, 1'b1};
    vec[6]  = '{8'h07, 1'b0, 8'h07, 1'b1};
    vec[7]  = '{8'h08, 1'b0, 8'h08, 1'b1};
    vec[8]  = '{8'h09, 1'b0, 8'h09, 1'b1};
    vec[9]  = '{8'h10, 1'b0, 8'h10, 1'b1};
    vec[10] = '{8'h11, 1'b0, 8'h11, 1'b1};
    vec[11] = '{8'h12, 1'b0, 8'h00, 1'b1};
    vec[12] = '{8'h01, 1'b1, 8'h13, 1'b1};
    vec[13] = '{8'h02, 1'b1, 8'h14, 1'b1};
    vec[14] = '{8'h03, 1'b1, 8'h15, 1'b1};
    vec[15] = '{8'h04, 1'b1, 8'h16, 1'b1};
    vec[16] = '{8'h05, 1'b1, 8'h17, 1'b1};
    vec[17] = '{8'h06, 1'b1, 8'h18, 1'b1};
    vec[18] = '{8'h07, 1'b1, 8'h19, 1'b1};
    vec[19] = '{8'h08, 1'b1, 8'h20, 1'b1};
    vec[20] = '{8'h09, 1'b1, 8'h21, 1'b1};
    vec[21] = '{8'h10, 1'b1, 8'h22, 1'b1};
    vec[22] = '{8'h11, 1'b1, 8'h23, 1'b1};
    vec[23] = '{8'h12, 1'b1, 8'h12, 1'b1};
    vec[24] = '{8'h00, 1'b0, 8'h00, 1'b0};
    vec[25] = '{8'h13, 1'b1, 8'h00, 1'b0};
    vec[26] = '{8'h0A, 1'b0, 8'h00, 1'b0};
    vec[27] = '{8'h20, 1'b1, 8'h00, 1'b0};

    // Reset state, sampled before the first rising edge.
    cur = 8'h00;
    #3;
    chk("rst_hour", Hour24, 8'h00);
    chk("rst_busy", Busy, 8'd0);
    chk("rst_done", Done, 8'd0);
    chk("rst_err", Err, 8'd0);
    chk("rst_day", DayCarry, 8'd0);
    @(negedge CLK);
    nCR = 1'b1;

    for (int i = 0; i < 28; i++)
      do_set($sformatf("vec%0d", i), vec[i].hr, vec[i].pm, vec[i].exp, vec[i].ok);

    // Carries through 23 -> 00 wrap, and the 09 -> 10 decimal carry.
    do_set("set22", 8'h10, 1'b1, 8'h22, 1'b1);
    carry1("c22", 8'h23, 1'b0);
    carry1("c23", 8'h00, 1'b1);
    @(negedge CLK);
    chk("day_off", DayCarry, 8'd0);
    do_set("set09", 8'h09, 1'b0, 8'h09, 1'b1);
    carry1("c09", 8'h10, 1'b0);

    // 11 PM with a carry in the CHECK cycle commits as 00 with DayCarry.
    @(negedge CLK);
    Load = 1'b1; Hour12 = 8'h11; PM = 1'b1;
    @(negedge CLK);
    Load = 1'b0; CarryIn = 1'b1;
    @(negedge CLK);
    CarryIn = 1'b0;
    chk("pend_busy", Busy, 8'd1);
    chk("pend_err", Err, 8'd0);
    @(negedge CLK);
    chk("pend_hour", Hour24, 8'h00);
    chk("pend_done", Done, 8'd1);
    chk("pend_day", DayCarry, 8'd1);
    cur = 8'h00;
    // A stale pending flag would make this set land on 06.
    do_set("after_pend", 8'h05, 1'b0, 8'h05, 1'b1);

    // Invalid set with a pending carry increments the old hour.
    @(negedge CLK);
    Load = 1'b1; Hour12 = 8'h13; PM = 1'b0;
    @(negedge CLK);
    Load = 1'b0; CarryIn = 1'b1;
    @(negedge CLK);
    CarryIn = 1'b0;
    chk("invp_err", Err, 8'd1);
    chk("invp_hour", Hour24, 8'h06);
    chk("invp_busy", Busy, 8'd0);
    @(negedge CLK);
    chk("invp_erroff", Err, 8'd0);
    cur = 8'h06;

    // Load and CarryIn together in IDLE: carry applies, then commit overwrites.
    @(negedge CLK);
    Load = 1'b1; Hour12 = 8'h03; PM = 1'b1; CarryIn = 1'b1;
    @(negedge CLK);
    Load = 1'b0; CarryIn = 1'b0;
    chk("lc_hour_carry", Hour24, 8'h07);
    chk("lc_busy", Busy, 8'd1);
    @(negedge CLK);
    @(negedge CLK);
    chk("lc_hour_commit", Hour24, 8'h15);
    chk("lc_done", Done, 8'd1);
    cur = 8'h15;

    // Reset asserted during CHECK aborts the set immediately.
    @(negedge CLK);
    Load = 1'b1; Hour12 = 8'h08; PM = 1'b0;
    @(negedge CLK);
    Load = 1'b0;
    chk("ra_busy", Busy, 8'd1);
    #2;
    nCR = 1'b0;
    #1;
    chk("ra_hour", Hour24, 8'h00);
    chk("ra_busy0", Busy, 8'd0);
    chk("ra_done", Done, 8'd0);
    chk("ra_err", Err, 8'd0);
    chk("ra_day", DayCarry, 8'd0);
    @(negedge CLK);
    nCR = 1'b1;
    @(negedge CLK);
    chk("ra_post_busy", Busy, 8'd0);
    chk("ra_post_done", Done, 8'd0);
    chk("ra_post_err", Err, 8'd0);
    chk("ra_post_hour", Hour24, 8'h00);
    @(negedge CLK);
    chk("ra_post2_done", Done, 8'd0);
    chk("ra_post2_err", Err, 8'd0);
    cur = 8'h00;
    do_set("ra_reset_set", 8'h04, 1'b1, 8'h16, 1'b1);

    // Load held for three edges: only the first is taken.
    @(negedge CLK);
    Load = 1'b1; Hour12 = 8'h02; PM = 1'b0;
    @(negedge CLK);
    Hour12 = 8'h07; PM = 1'b1;
    chk("hold_busy1", Busy, 8'd1);
    @(negedge CLK);
    chk("hold_busy2", Busy, 8'd1);
    chk("hold_err", Err, 8'd0);
    @(negedge CLK);
    Load = 1'b0;
    chk("hold_hour", Hour24, 8'h02);
    chk("hold_done", Done, 8'd1);
    chk("hold_busy3", Busy, 8'd0);
    @(negedge CLK);
    chk("hold_busy4", Busy, 8'd0);
    chk("hold_done2", Done, 8'd0);
    chk("hold_hour2", Hour24, 8'h02);
    @(negedge CLK);
    chk("hold_busy5", Busy, 8'd0);
    chk("hold_done3", Done, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
